// File: rtl/bram_axil_pkg.sv
// bram_axil_pkg: shared response codes, types and constant helpers for bram_axil
package bram_axil_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    function automatic int clog2(input int v);
        int r = 0;
        while ((64'(1) << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// bram_sdp_core: simple-dual-port block RAM with byte-enabled write port and registered read-first read port
module bram_sdp_core #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 15,
  parameter int DEPTH      = 32768,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH/8-1:0] i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [AW-1:0]           i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH / 8; b++)
      if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    if (rst) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/bram_axil.sv
// bram_axil: AXI4-Lite block RAM slave with buffered AW/W, held B/R responses and optional range errors
//   clk, rst                                 : clock, sync active-high reset (memory contents persist)
//   i_awvalid, o_awready, i_awaddr           : write address channel
//   i_wvalid, o_wready, i_wdata, i_wstrb     : write data channel
//   o_bvalid, i_bready, o_bresp              : write response channel
//   i_arvalid, o_arready, i_araddr           : read address channel
//   o_rvalid, i_rready, o_rdata, o_rresp     : read response channel
//   BRAM_AXIL_ERR_EN defined: word index >= DEPTH answers SLVERR and touches nothing;
//   undefined: index truncated to clog2(DEPTH) bits and responses are always OKAY.
module bram_axil
    import bram_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int DEPTH      = 32768,
    parameter     INIT_FILE  = "boot.hex"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [1:0]              o_bresp,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = clog2(NB);
    localparam int IW  = ADDR_WIDTH - OFF;
    localparam int AW  = clog2(DEPTH) < 1 ? 1 : clog2(DEPTH);

    logic                  r_aw_full, r_w_full, r_bvalid, r_rvalid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;
    resp_t                 r_bresp, r_rresp;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wok, w_rok, w_unused;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata, w_dout;
    logic [NB-1:0]         w_wstrb;
    logic [IW-1:0]         w_widx, w_ridx;

    // Readies are forced low for the whole reset cycle so nothing is accepted while state clears.
    assign o_awready = !r_aw_full && !rst;
    assign o_wready  = !r_w_full && !rst;
    assign o_arready = (!r_rvalid || i_rready) && !rst;
    assign w_aw_hs   = i_awvalid && o_awready;
    assign w_w_hs    = i_wvalid && o_wready;
    assign w_ar_hs   = i_arvalid && o_arready;

    // A buffered beat wins; otherwise the beat handshaking this cycle is used directly.
    assign w_waddr  = r_aw_full ? r_awaddr : i_awaddr;
    assign w_wdata  = r_w_full ? r_wdata : i_wdata;
    assign w_wstrb  = r_w_full ? r_wstrb : i_wstrb;
    assign w_commit = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs) && (!r_bvalid || i_bready) && !rst;

    assign w_widx   = w_waddr[ADDR_WIDTH-1:OFF];
    assign w_ridx   = i_araddr[ADDR_WIDTH-1:OFF];
    assign w_unused = ^{w_waddr, i_araddr};

`ifdef BRAM_AXIL_ERR_EN
    assign w_wok = 64'(w_widx) < 64'(DEPTH);
    assign w_rok = 64'(w_ridx) < 64'(DEPTH);
`else
    assign w_wok = 1'b1;
    assign w_rok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_aw_full <= w_commit ? 1'b0 : (w_aw_hs ? 1'b1 : r_aw_full);
            r_w_full  <= w_commit ? 1'b0 : (w_w_hs ? 1'b1 : r_w_full);
            r_bvalid  <= w_commit ? 1'b1 : (i_bready ? 1'b0 : r_bvalid);
            r_rvalid  <= w_ar_hs ? 1'b1 : (i_rready ? 1'b0 : r_rvalid);
            r_bresp   <= w_commit ? (w_wok ? RESP_OKAY : RESP_SLVERR) : r_bresp;
            r_rresp   <= w_ar_hs ? (w_rok ? RESP_OKAY : RESP_SLVERR) : r_rresp;
        end
    end

    always_ff @(posedge clk) begin
        r_awaddr <= w_aw_hs ? i_awaddr : r_awaddr;
        r_wdata  <= w_w_hs ? i_wdata : r_wdata;
        r_wstrb  <= w_w_hs ? i_wstrb : r_wstrb;
    end

    bram_sdp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW),
        .DEPTH      (DEPTH),
        .INIT_FILE  (INIT_FILE)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_we    ({NB{w_commit && w_wok}} & w_wstrb),
        .i_waddr (w_widx[AW-1:0]),
        .i_wdata (w_wdata),
        .i_re    (w_ar_hs && w_rok),
        .i_raddr (w_ridx[AW-1:0]),
        .o_rdata (w_dout)
    );

    // The core read register is left untouched on an error read, so the zero is applied here.
    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_rvalid = r_rvalid;
    assign o_rresp  = r_rresp;
    assign o_rdata  = (r_rresp == RESP_SLVERR) ? '0 : w_dout;

endmodule

// File: tb/tb_bram_axil.sv
// tb_bram_axil: directed + randomized self-checking bench for bram_axil against a word-array model
module tb_bram_axil;

    localparam int DW = 32, AWD = 12, DEPTH = 1000, NW = 64;

    logic clk = 1'b0, rst = 1'b1;
    logic i_awvalid = 0, o_awready, i_wvalid = 0, o_wready, o_bvalid, i_bready = 0;
    logic i_arvalid = 0, o_arready, o_rvalid, i_rready = 0;
    logic [AWD-1:0] i_awaddr = 0, i_araddr = 0;
    logic [DW-1:0] i_wdata = 0, o_rdata;
    logic [3:0] i_wstrb = 0;
    logic [1:0] o_bresp, o_rresp;

    int tests = 0, fails = 0;
    logic [31:0] mem [NW];
    logic [31:0] d1, d2, hold;
    logic [AWD-1:0] a;
    int ra [8];

    always #5 clk = ~clk;

    bram_axil #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .DEPTH(DEPTH), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AWD-1:0] ad, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
        int n = 0;
        i_awvalid = 1; i_awaddr = ad; i_wvalid = 1; i_wdata = d; i_wstrb = s; i_bready = 1;
        while (!(o_awready && o_wready) && n < 20) begin tick(); n++; end
        tick();
        i_awvalid = 0; i_wvalid = 0;
        n = 0;
        while (!o_bvalid && n < 20) begin tick(); n++; end
        check("wr_bvalid", 64'(o_bvalid), 64'(1));
        check("wr_bresp", 64'(o_bresp), 64'(er));
        tick();
        if (er == 2'b00 && int'(ad >> 2) < NW) mem[ad >> 2] = merge(mem[ad >> 2], d, s);
    endtask

    task automatic rd(input logic [AWD-1:0] ad, input logic [31:0] exp, input logic [1:0] er);
        int n = 0;
        i_arvalid = 1; i_araddr = ad; i_rready = 1;
        while (!o_arready && n < 20) begin tick(); n++; end
        tick();
        i_arvalid = 0;
        check("rd_rvalid", 64'(o_rvalid), 64'(1));
        check("rd_rdata", 64'(o_rdata), 64'(exp));
        check("rd_rresp", 64'(o_rresp), 64'(er));
        tick();
    endtask

    initial begin
        tick(); tick();
        check("rst_awready", 64'(o_awready), 64'(0));
        check("rst_wready", 64'(o_wready), 64'(0));
        check("rst_arready", 64'(o_arready), 64'(0));
        check("rst_bvalid", 64'(o_bvalid), 64'(0));
        check("rst_rvalid", 64'(o_rvalid), 64'(0));
        check("rst_bresp", 64'(o_bresp), 64'(0));
        check("rst_rresp", 64'(o_rresp), 64'(0));
        rst = 0;
        tick();
        check("post_rst_awready", 64'(o_awready), 64'(1));
        check("post_rst_wready", 64'(o_wready), 64'(1));
        check("post_rst_arready", 64'(o_arready), 64'(1));
        for (int i = 0; i < NW; i++) wr(AWD'(i * 4), $urandom, 4'hF, 2'b00);
        // word 0 as the boot instruction, then the byte-strobe merge case
        wr(0, 32'h0000_0013, 4'hF, 2'b00);
        rd(0, 32'h0000_0013, 2'b00);
        wr(12'h040, 32'h1111_1111, 4'hF, 2'b00);
        wr(12'h040, 32'hDEAD_BEEF, 4'b0101, 2'b00);
        rd(12'h040, 32'h11AD_11EF, 2'b00);
        // random mix; low byte-offset bits must be ignored
        for (int i = 0; i < 40; i++) begin
            a = AWD'($urandom_range(0, NW - 1) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) wr(a, $urandom, 4'($urandom_range(0, 15)), 2'b00);
            else rd(a, mem[a >> 2], 2'b00);
        end
        // back-to-back reads, one per cycle
        i_rready = 1;
        for (int k = 0; k < 8; k++) begin
            ra[k] = $urandom_range(0, NW - 1);
            i_arvalid = 1; i_araddr = AWD'(ra[k] * 4);
            check("burst_arready", 64'(o_arready), 64'(1));
            tick();
            check("burst_rvalid", 64'(o_rvalid), 64'(1));
            check("burst_rdata", 64'(o_rdata), 64'(mem[ra[k]]));
        end
        i_arvalid = 0;
        tick();
        // back-to-back writes, one per cycle
        i_bready = 1;
        for (int k = 0; k < 6; k++) begin
            d1 = $urandom;
            i_awvalid = 1; i_awaddr = AWD'((20 + k) * 4); i_wvalid = 1; i_wdata = d1; i_wstrb = 4'hF;
            check("bwr_ready", 64'({o_awready, o_wready}), 64'(3));
            tick();
            check("bwr_bvalid", 64'(o_bvalid), 64'(1));
            mem[20 + k] = d1;
        end
        i_awvalid = 0; i_wvalid = 0;
        tick();
        for (int k = 0; k < 6; k++) rd(AWD'((20 + k) * 4), mem[20 + k], 2'b00);
        // W arrives 3 cycles before AW
        d1 = $urandom;
        i_wvalid = 1; i_wdata = d1; i_wstrb = 4'hF; i_bready = 1;
        tick();
        i_wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            check("wfirst_wready", 64'(o_wready), 64'(0));
            check("wfirst_no_b", 64'(o_bvalid), 64'(0));
            tick();
        end
        i_awvalid = 1; i_awaddr = 12'h0C0;
        check("wfirst_awready", 64'(o_awready), 64'(1));
        tick();
        i_awvalid = 0;
        check("wfirst_bvalid", 64'(o_bvalid), 64'(1));
        tick();
        check("wfirst_b_once", 64'(o_bvalid), 64'(0));
        mem[48] = d1;
        rd(12'h0C0, mem[48], 2'b00);
        // B stall: one further AW/W buffered, then readies drop
        d1 = $urandom; d2 = $urandom;
        i_bready = 0;
        i_awvalid = 1; i_awaddr = 12'h028; i_wvalid = 1; i_wdata = d1; i_wstrb = 4'hF;
        tick();
        check("bstall_b1", 64'(o_bvalid), 64'(1));
        i_awaddr = 12'h02C; i_wdata = d2;
        check("bstall_ready2", 64'({o_awready, o_wready}), 64'(3));
        tick();
        i_awvalid = 0; i_wvalid = 0;
        for (int k = 0; k < 4; k++) begin
            check("bstall_ready_low", 64'({o_awready, o_wready}), 64'(0));
            check("bstall_bhold", 64'({o_bvalid, o_bresp}), 64'(4));
            tick();
        end
        i_bready = 1;
        tick();
        check("bstall_b2", 64'(o_bvalid), 64'(1));
        check("bstall_ready_back", 64'({o_awready, o_wready}), 64'(3));
        tick();
        check("bstall_b_done", 64'(o_bvalid), 64'(0));
        mem[10] = d1; mem[11] = d2;
        rd(12'h028, mem[10], 2'b00);
        rd(12'h02C, mem[11], 2'b00);
        // R stall: data held, arready low, queued AR taken on release
        i_rready = 0;
        i_arvalid = 1; i_araddr = 12'h010;
        tick();
        i_araddr = 12'h014;
        for (int k = 0; k < 4; k++) begin
            check("rstall_rvalid", 64'(o_rvalid), 64'(1));
            check("rstall_rdata", 64'(o_rdata), 64'(mem[4]));
            check("rstall_arready", 64'(o_arready), 64'(0));
            tick();
        end
        i_rready = 1;
        tick();
        i_arvalid = 0;
        check("rstall_next", 64'({o_rvalid, o_rdata}), {31'd0, 1'b1, mem[5]});
        tick();
        check("rstall_done", 64'(o_rvalid), 64'(0));
        // same-cycle write and read of one word returns old data
        hold = mem[30]; d1 = ~hold;
        i_awvalid = 1; i_awaddr = 12'h078; i_wvalid = 1; i_wdata = d1; i_wstrb = 4'hF;
        i_arvalid = 1; i_araddr = 12'h078;
        tick();
        i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
        check("coll_old", 64'(o_rdata), 64'(hold));
        check("coll_b", 64'(o_bvalid), 64'(1));
        mem[30] = d1;
        tick();
        rd(12'h078, mem[30], 2'b00);
`ifdef BRAM_AXIL_ERR_EN
        hold = mem[0];
        wr(12'hFA0, 32'hCAFE_F00D, 4'hF, 2'b10);
        rd(12'h000, hold, 2'b00);
        rd(12'hFA0, 32'h0, 2'b10);
        rd(12'h000, hold, 2'b00);
`endif
        // reset with a pending B, a pending R and a buffered AW
        d1 = $urandom; d2 = ~mem[6];
        i_bready = 0; i_rready = 0;
        i_awvalid = 1; i_awaddr = 12'h014; i_wvalid = 1; i_wdata = d1; i_wstrb = 4'hF;
        i_arvalid = 1; i_araddr = 12'h020;
        tick();
        mem[5] = d1;
        i_wvalid = 0; i_arvalid = 0; i_awaddr = 12'h018;
        tick();
        i_awvalid = 0;
        check("prerst_aw_buffered", 64'(o_awready), 64'(0));
        check("prerst_rvalid", 64'(o_rvalid), 64'(1));
        rst = 1;
        tick();
        check("midrst_awready", 64'(o_awready), 64'(0));
        check("midrst_bvalid", 64'(o_bvalid), 64'(0));
        check("midrst_rvalid", 64'(o_rvalid), 64'(0));
        check("midrst_rdata", 64'(o_rdata), 64'(0));
        rst = 0;
        tick();
        check("postrst_ready", 64'({o_awready, o_wready}), 64'(3));
        i_bready = 1; i_rready = 1;
        i_wvalid = 1; i_wdata = d2; i_wstrb = 4'hF;
        tick();
        i_wvalid = 0;
        tick(); tick();
        check("postrst_no_commit", 64'(o_bvalid), 64'(0));
        i_awvalid = 1; i_awaddr = 12'h01C;
        tick();
        i_awvalid = 0;
        check("postrst_b", 64'(o_bvalid), 64'(1));
        mem[7] = d2;
        tick();
        rd(12'h018, mem[6], 2'b00);
        rd(12'h01C, mem[7], 2'b00);
        rd(12'h014, mem[5], 2'b00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
